// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
//   sw_state_e   : control FSM state encoding
//   bcd_time_t   : four BCD digits, index 0 = hundredths, index 3 = tens of seconds
//   an_onehot0() : active-low anode pattern for a scan index
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_e;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned DP_INDEX   = 2;
   localparam logic [DIGIT_W-1:0]    BCD_MAX = 4'd9;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE = 4'b1111;

   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_time_t;

   // Drive low only the anode of the selected digit.
   function automatic logic [NUM_DIGITS-1:0] an_onehot0(input logic [IDX_W-1:0] idx);
      return AN_IDLE & ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/stopwatch_core_bcd_decade.sv
// One BCD decade of the time counter.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : increment enable (tick or carry from lower decade)
//   digit      : current digit value, 0..9
//   carry_c    : combinational carry, high when inc wraps 9 -> 0
module bcd_decade
   import stopwatch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry_c
);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;

   // Next digit value and carry; values above 9 are treated as 9 so the digit never leaves 0..9.
   always_comb begin
      digit_d = digit_q;
      carry_c = 1'b0;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         if (digit_q >= BCD_MAX) begin
            digit_d = '0;
            carry_c = 1'b1;
         end else begin
            digit_d = digit_q + DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) digit_q <= '0;
      else       digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timebase, control FSM and digit scanner.
//   clk, reset     : clock, async active-high reset
//   btn_startstop  : start/stop button level (rising edge = event)
//   btn_lap        : lap button level (rising edge = event)
//   btn_clear      : clear button level (rising edge = event)
//   digit_out      : BCD nibble of the scanned digit
//   an             : active-low digit anodes
//   dp             : active-low decimal point (lit on seconds-ones digit)
//   running        : high in RUN or LAP
//   overflow       : sticky 99.99 -> 00.00 wrap flag
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 500000,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_startstop,
   input  logic                  btn_lap,
   input  logic                  btn_clear,
   output logic [DIGIT_W-1:0]    digit_out,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  dp,
   output logic                  running,
   output logic                  overflow
);

   localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   sw_state_e             state_q,     state_d;
   logic [PRE_W-1:0]      presc_q,     presc_d;
   logic [SLOT_W-1:0]     slot_q,      slot_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic                  ss_prev_q,   lap_prev_q,  clr_prev_q;
   bcd_time_t             lap_q,       lap_d;
   logic [DIGIT_W-1:0]    digit_out_q, digit_out_d;
   logic [NUM_DIGITS-1:0] an_q,        an_d;
   logic                  dp_q,        dp_d;
   logic                  running_q,   running_d;
   logic                  overflow_q,  overflow_d;

   logic      ss_ev_c, lap_ev_c, clr_ev_c;
   logic      counting_c, tick_c, clear_c;
   logic      carry0_c, carry1_c, carry2_c, wrap_c;
   bcd_time_t live_c, disp_c;

   // Rising-edge events with fixed priority startstop > lap > clear.
   always_comb begin
      ss_ev_c  = btn_startstop & ~ss_prev_q;
      lap_ev_c = btn_lap & ~lap_prev_q & ~ss_ev_c;
      clr_ev_c = btn_clear & ~clr_prev_q & ~ss_ev_c & ~lap_ev_c;
   end

   // Control FSM next state and lap capture.
   always_comb begin
      state_d = state_q;
      lap_d   = lap_q;
      clear_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ss_ev_c) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ss_ev_c) begin
               state_d = ST_PAUSE;
            end else if (lap_ev_c) begin
               state_d = ST_LAP;
               lap_d   = live_c;
            end
         end
         ST_LAP: begin
            if (ss_ev_c)       state_d = ST_PAUSE;
            else if (lap_ev_c) state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (ss_ev_c) begin
               state_d = ST_RUN;
            end else if (clr_ev_c) begin
               state_d = ST_IDLE;
               clear_c = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler only advances while counting, so PAUSE keeps the fractional hundredth.
   always_comb begin
      counting_c = (state_q == ST_RUN) || (state_q == ST_LAP);
      tick_c     = counting_c && (presc_q == PRE_W'(TICK_DIV - 1));
      presc_d    = presc_q;
      if (clear_c)     presc_d = '0;
      else if (tick_c) presc_d = '0;
      else if (counting_c) presc_d = presc_q + PRE_W'(1);
   end

   // Four-decade BCD carry chain; carry out of the top decade is the 99.99 wrap.
   bcd_decade u_d0 (.clk(clk), .reset(reset), .clr(clear_c), .inc(tick_c),
                    .digit(live_c[0]), .carry_c(carry0_c));
   bcd_decade u_d1 (.clk(clk), .reset(reset), .clr(clear_c), .inc(carry0_c),
                    .digit(live_c[1]), .carry_c(carry1_c));
   bcd_decade u_d2 (.clk(clk), .reset(reset), .clr(clear_c), .inc(carry1_c),
                    .digit(live_c[2]), .carry_c(carry2_c));
   bcd_decade u_d3 (.clk(clk), .reset(reset), .clr(clear_c), .inc(carry2_c),
                    .digit(live_c[3]), .carry_c(wrap_c));

   // Status flags.
   always_comb begin
      overflow_d = clear_c ? 1'b0 : (overflow_q | wrap_c);
      running_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
   end

   // Free-running scanner; outputs are registered from the current index.
   always_comb begin
      disp_c      = (state_q == ST_LAP) ? lap_q : live_c;
      slot_d      = slot_q + SLOT_W'(1);
      idx_d       = idx_q;
      if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
         slot_d = '0;
         idx_d  = idx_q + IDX_W'(1);
      end
      digit_out_d = disp_c[idx_q];
      an_d        = an_onehot0(idx_q);
      dp_d        = (idx_q != IDX_W'(DP_INDEX));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         slot_q      <= '0;
         idx_q       <= '0;
         ss_prev_q   <= 1'b0;
         lap_prev_q  <= 1'b0;
         clr_prev_q  <= 1'b0;
         lap_q       <= '0;
         digit_out_q <= '0;
         an_q        <= 4'b1110;
         dp_q        <= 1'b1;
         running_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         slot_q      <= slot_d;
         idx_q       <= idx_d;
         ss_prev_q   <= btn_startstop;
         lap_prev_q  <= btn_lap;
         clr_prev_q  <= btn_clear;
         lap_q       <= lap_d;
         digit_out_q <= digit_out_d;
         an_q        <= an_d;
         dp_q        <= dp_d;
         running_q   <= running_d;
         overflow_q  <= overflow_d;
      end
   end

   assign digit_out = digit_out_q;
   assign an        = an_q;
   assign dp        = dp_q;
   assign running   = running_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with small dividers.
// The reference model tracks elapsed counting cycles as one integer and
// derives the time, scan position and flags from it arithmetically.
module tb_stopwatch_core;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_startstop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
   logic [3:0] digit_out, an;
   logic       dp, running, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int m_state, m_cyc, m_lap, m_scan;
   logic m_pss, m_plp, m_pcl;

   typedef struct {
      logic       ss, lp, cl;
      logic [3:0] an;
      logic [3:0] dig;
      logic       dp;
   } vec_t;
   vec_t tbl[8];

   stopwatch_core #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset(reset),
      .btn_startstop(btn_startstop), .btn_lap(btn_lap), .btn_clear(btn_clear),
      .digit_out(digit_out), .an(an), .dp(dp), .running(running), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int digit_of(input int val, input int idx);
      int v = val;
      for (int j = 0; j < idx; j++) v = v / 10;
      return v % 10;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_cyc = 0; m_lap = 0; m_scan = 0;
      m_pss = 1'b0; m_plp = 1'b0; m_pcl = 1'b0;
   endtask

   // One clock with the given button levels; every output is checked against the model.
   task automatic step(input logic ss, input logic lp, input logic cl);
      int idx, live_pre, disp;
      logic ev_ss, ev_lp, ev_cl;
      logic [3:0] e_an, e_dig;
      logic e_dp, e_run, e_ovf;
      btn_startstop = ss; btn_lap = lp; btn_clear = cl;
      live_pre = (m_cyc / TICK_DIV) % 10000;
      disp  = (m_state == M_LAP) ? m_lap : live_pre;
      idx   = (m_scan / SCAN_DIV) % 4;
      e_an  = 4'b1111 ^ (4'b0001 << idx);
      e_dig = 4'(digit_of(disp, idx));
      e_dp  = (idx != 2);
      ev_ss = ss & ~m_pss;
      ev_lp = lp & ~m_plp & ~ev_ss;
      ev_cl = cl & ~m_pcl & ~ev_ss & ~ev_lp;
      if (m_state == M_RUN || m_state == M_LAP) m_cyc++;
      case (m_state)
         M_IDLE:  if (ev_ss) m_state = M_RUN;
         M_RUN:   if (ev_ss) m_state = M_PAUSE;
                  else if (ev_lp) begin m_state = M_LAP; m_lap = live_pre; end
         M_LAP:   if (ev_ss) m_state = M_PAUSE; else if (ev_lp) m_state = M_RUN;
         default: if (ev_ss) m_state = M_RUN;
                  else if (ev_cl) begin m_state = M_IDLE; m_cyc = 0; end
      endcase
      e_run = (m_state == M_RUN) || (m_state == M_LAP);
      e_ovf = (m_cyc / TICK_DIV) >= 10000;
      m_pss = ss; m_plp = lp; m_pcl = cl;
      m_scan++;
      @(posedge clk); #1;
      check("cycle {an,digit,dp,run,ovf}", {an, digit_out, dp, running, overflow},
            {e_an, e_dig, e_dp, e_run, e_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Collect one full scan of the (static) display as a decimal value.
   task automatic read_display(output int val);
      int dv[4];
      for (int i = 0; i < 4; i++) dv[i] = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0);
         case (an)
            4'b1110: dv[0] = int'(digit_out);
            4'b1101: dv[1] = int'(digit_out);
            4'b1011: dv[2] = int'(digit_out);
            4'b0111: dv[3] = int'(digit_out);
            default: ;
         endcase
      end
      val = dv[0] + 10 * dv[1] + 100 * dv[2] + 1000 * dv[3];
   endtask

   task automatic do_reset();
      btn_startstop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Start, accumulate 'n' counting cycles, and pause again.
   task automatic run_and_pause(input int n);
      step(1'b1, 1'b0, 1'b0);
      idle(n - 1);
      step(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int val, found;
      logic [3:0] last_an;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 4'b1110, 4'd4, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 4'b1110, 4'd4, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 4'b1101, 4'd3, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 4'b1101, 4'd3, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 4'b1011, 4'd2, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 4'b1011, 4'd2, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0111, 4'd1, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 4'b0111, 4'd1, 1'b1};

      // Reset mid-run at 03.27
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(327 * TICK_DIV);
      check("t1 running before reset", running, 1);
      reset = 1'b1;
      #1;
      check("t1 reset outputs {an,digit,dp,run,ovf}", {an, digit_out, dp, running, overflow},
            {4'b1110, 4'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      read_display(val);
      check("t1 display after reset", val, 0);

      // Pause preserves time and fractional count
      do_reset();
      run_and_pause(401);
      check("t2 running in pause", running, 0);
      read_display(val);
      check("t2 paused display", val, 100);
      idle(100);
      read_display(val);
      check("t2 display held", val, 100);
      step(1'b1, 1'b0, 1'b0);
      check("t2 resumed", running, 1);
      idle(40);

      // Carry into tens and full wrap with overflow, then clear
      do_reset();
      run_and_pause(999 * TICK_DIV);
      read_display(val);
      check("t3 09.99", val, 999);
      run_and_pause(TICK_DIV);
      read_display(val);
      check("t3 10.00", val, 1000);
      run_and_pause(9999 * TICK_DIV - 1000 * TICK_DIV);
      read_display(val);
      check("t3 99.99", val, 9999);
      check("t3 no overflow yet", overflow, 0);
      run_and_pause(TICK_DIV);
      read_display(val);
      check("t3 wrap 00.00", val, 0);
      check("t3 overflow set", overflow, 1);
      step(1'b0, 1'b0, 1'b1);
      check("t3 cleared running", running, 0);
      check("t3 overflow cleared", overflow, 0);
      read_display(val);
      check("t3 cleared display", val, 0);
      step(1'b0, 1'b0, 1'b0);
      check("t3 idle overflow", overflow, 0);

      // Lap freeze at 00.05, then release to live
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(5 * TICK_DIV);
      step(1'b0, 1'b1, 1'b0);
      idle(72);
      read_display(val);
      check("t4 lap display frozen", val, 5);
      check("t4 running in lap", running, 1);
      step(1'b0, 1'b1, 1'b0);
      check("t4 running after second lap", running, 1);
      step(1'b1, 1'b0, 1'b0);
      read_display(val);
      check("t4 live after lap", val, 25);

      // Priority, ignored clear in RUN, held button
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(39);
      step(1'b1, 1'b1, 1'b0);
      check("t5 ss wins over lap", running, 0);
      read_display(val);
      check("t5 no lap latch", val, 10);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check("t5 clear ignored in run", running, 1);
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);
      check("t5 held ss single event", running, 0);
      step(1'b0, 1'b0, 1'b0);
      read_display(val);
      check("t5 display after hold", val, 10);

      // Scan order with 12.34 on display
      do_reset();
      run_and_pause(1234 * TICK_DIV);
      found = 0;
      last_an = an;
      for (int i = 0; i < 16 && found == 0; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (an == 4'b1110 && last_an != 4'b1110) found = 1;
         last_an = an;
      end
      check("t6 scan alignment found", found, 1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step(tbl[i].ss, tbl[i].lp, tbl[i].cl);
         check($sformatf("t6 scan[%0d] {an,digit,dp}", i), {an, digit_out, dp},
               {tbl[i].an, tbl[i].dig, tbl[i].dp});
      end

      // Random buttons against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step(1'(($urandom % 10) == 0), 1'(($urandom % 12) == 0), 1'(($urandom % 12) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
